// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: UART with TX/RX FIFOs, 16x baud generator and a 4-register bus
// Ports: clk, Rst (async active-low), rx serial in, tx serial out,
//        uart_addr/tx_wen/rx_ren/uart_din register bus, uart_dout registered read data,
//        uart_IRQ registered level interrupt.
module uart_fifo_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DEF_DIV    = 26,
   parameter bit PARITY_EN  = 1'b0
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       rx,
   output logic       tx,
   input  logic [1:0] uart_addr,
   input  logic       tx_wen,
   input  logic       rx_ren,
   input  logic [7:0] uart_din,
   output logic [7:0] uart_dout,
   output logic       uart_IRQ
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_t;
   logic rd, wr_data, rd_data, rd_stat;
   logic [7:0] div_q, bcnt_q, dout_q, rd_val, status;
   logic [2:0] ier_q;
   logic [3:0] stk_q;
   logic tick, irq_q;
   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, rx_push_ok;
   logic [DATA_BITS-1:0] tx_head, rx_head;
   tx_st_t tx_st_q;
   logic [3:0] tx_tc_q;
   logic [2:0] tx_bit_q;
   logic [DATA_BITS-1:0] tx_sh_q;
   logic tx_par_q, tx_q, tx_end, tx_idle;
   rx_st_t rx_st_q;
   logic [3:0] rx_tc_q;
   logic [2:0] rx_bit_q;
   logic [DATA_BITS-1:0] rx_sh_q;
   logic rx_s1_q, rx_s2_q, rx_s3_q, rx_smp;
   logic perr_ev, ferr_ev, rxovr_ev, txovr_ev;

   // a write wins over a simultaneous read
   assign rd      = rx_ren & ~tx_wen;
   assign wr_data = tx_wen && uart_addr == 2'd0;
   assign rd_data = rd && uart_addr == 2'd0;
   assign rd_stat = rd && uart_addr == 2'd1;

   assign tick = bcnt_q == 8'd0;

   assign tx_empty = tx_wp_q == tx_rp_q;
   assign tx_full  = tx_wp_q[AW] != tx_rp_q[AW] && tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0];
   assign rx_empty = rx_wp_q == rx_rp_q;
   assign rx_full  = rx_wp_q[AW] != rx_rp_q[AW] && rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0];
   assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
   assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

   assign tx_push    = wr_data & ~tx_full;
   assign rx_pop     = rd_data & ~rx_empty;
   // a pop in the same cycle frees the slot a full FIFO needs
   assign rx_push_ok = rx_push & (~rx_full | rx_pop);

   assign tx_end  = tick && tx_tc_q == 4'd15;
   assign tx_pop  = tick && !tx_empty && (tx_st_q == T_IDLE || (tx_st_q == T_STOP && tx_tc_q == 4'd15));
   assign tx_idle = tx_empty && tx_st_q == T_IDLE;

   assign rx_smp   = tick && rx_tc_q == 4'd15;
   assign rx_push  = rx_smp && rx_st_q == R_STOP;
   assign perr_ev  = rx_smp && rx_st_q == R_PAR && rx_s2_q != ^rx_sh_q;
   assign ferr_ev  = rx_push && !rx_s2_q;
   assign rxovr_ev = rx_push && !rx_push_ok;
   assign txovr_ev = wr_data && tx_full;

   always_comb begin
      status = {1'b0, stk_q, tx_idle, tx_full, ~rx_empty};
      rd_val = uart_addr == 2'd0 ? (rx_empty ? 8'h00 : 8'(rx_head)) :
               uart_addr == 2'd1 ? status :
               uart_addr == 2'd2 ? {5'b0, ier_q} : div_q;
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= uart_din[DATA_BITS-1:0];
      if (rx_push_ok) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
   end

   always_ff @(posedge clk or negedge Rst)
      if (!Rst) begin
         div_q   <= 8'(DEF_DIV);
         bcnt_q  <= 8'(DEF_DIV);
         ier_q   <= '0;
         stk_q   <= '0;
         dout_q  <= '0;
         irq_q   <= 1'b0;
         tx_wp_q <= '0;
         tx_rp_q <= '0;
         rx_wp_q <= '0;
         rx_rp_q <= '0;
      end else begin
         bcnt_q <= tick ? div_q : bcnt_q - 8'd1;
         if (tx_wen && uart_addr == 2'd2) ier_q <= uart_din[2:0];
         if (tx_wen && uart_addr == 2'd3) div_q <= uart_din;
         // an error arriving on the clearing read stays set
         stk_q  <= (rd_stat ? 4'b0 : stk_q) | {txovr_ev, perr_ev, ferr_ev, rxovr_ev};
         dout_q <= rd ? rd_val : dout_q;
         irq_q  <= (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_idle) | (ier_q[2] & |stk_q);
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
         if (rx_push_ok) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
      end

   // tick counter free-runs and wraps every 16 ticks; a pop restarts it for the new frame
   always_ff @(posedge clk or negedge Rst)
      if (!Rst) begin
         tx_st_q  <= T_IDLE;
         tx_tc_q  <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_par_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         if (tick) tx_tc_q <= tx_tc_q + 4'd1;
         if (tx_pop) begin
            tx_st_q  <= T_START;
            tx_tc_q  <= '0;
            tx_sh_q  <= tx_head;
            tx_par_q <= ^tx_head;
            tx_q     <= 1'b0;
         end else if (tx_end)
            case (tx_st_q)
               T_START: begin
                  tx_st_q  <= T_DATA;
                  tx_bit_q <= '0;
                  tx_q     <= tx_sh_q[0];
               end
               T_DATA:
                  if (tx_bit_q == 3'(DATA_BITS-1)) begin
                     tx_st_q <= PARITY_EN ? T_PAR : T_STOP;
                     tx_q    <= PARITY_EN ? tx_par_q : 1'b1;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     tx_sh_q  <= tx_sh_q >> 1;
                     tx_q     <= tx_sh_q[1];
                  end
               T_PAR: begin
                  tx_st_q <= T_STOP;
                  tx_q    <= 1'b1;
               end
               T_STOP: tx_st_q <= T_IDLE;
               default: tx_st_q <= tx_st_q;
            endcase
      end

   always_ff @(posedge clk or negedge Rst)
      if (!Rst) begin
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
         rx_s3_q  <= 1'b1;
         rx_st_q  <= R_IDLE;
         rx_tc_q  <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
         if (tick) rx_tc_q <= rx_tc_q + 4'd1;
         case (rx_st_q)
            R_IDLE:
               if (rx_s3_q && !rx_s2_q) begin
                  rx_st_q <= R_START;
                  rx_tc_q <= '0;
               end
            // half-bit check: a line back high by now was a glitch
            R_START:
               if (tick && rx_tc_q == 4'd7) begin
                  rx_st_q  <= rx_s2_q ? R_IDLE : R_DATA;
                  rx_tc_q  <= '0;
                  rx_bit_q <= '0;
               end
            R_DATA:
               if (rx_smp) begin
                  rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                  rx_bit_q <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'(DATA_BITS-1)) rx_st_q <= PARITY_EN ? R_PAR : R_STOP;
               end
            R_PAR: if (rx_smp) rx_st_q <= R_STOP;
            default: if (rx_smp) rx_st_q <= R_IDLE;
         endcase
      end

   assign tx        = tx_q;
   assign uart_dout = dout_q;
   assign uart_IRQ  = irq_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: self-checking bench for uart_fifo_ctrl (8N1 and 8E1 instances)
module tb_uart_fifo_ctrl;
   typedef struct {
      logic [1:0] a;
      logic       w;
      logic       r;
      logic [7:0] d;
      logic [7:0] e_dout;
      logic       e_irq;
   } vec_t;

   logic clk = 1'b0, Rst = 1'b0, rx_drv = 1'b1, loop = 1'b0;
   logic [1:0] addr = '0;
   logic wen = 1'b0, ren = 1'b0;
   logic [7:0] din = '0;
   logic rx, tx0, tx1, irq0, irq1;
   logic [7:0] dout0, dout1, d;
   logic [9:0] fr;
   logic [7:0] sb[$];
   vec_t vt[12];
   int pass_n = 0, tot_n = 0, n;

   assign rx = loop ? tx0 : rx_drv;
   always #5 clk = ~clk;

   uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(16), .DEF_DIV(26), .PARITY_EN(1'b0)) u0 (
      .clk(clk), .Rst(Rst), .rx(rx), .tx(tx0), .uart_addr(addr), .tx_wen(wen),
      .rx_ren(ren), .uart_din(din), .uart_dout(dout0), .uart_IRQ(irq0));
   uart_fifo_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(16), .DEF_DIV(26), .PARITY_EN(1'b1)) u1 (
      .clk(clk), .Rst(Rst), .rx(rx), .tx(tx1), .uart_addr(addr), .tx_wen(wen),
      .rx_ren(ren), .uart_din(din), .uart_dout(dout1), .uart_IRQ(irq1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v);
      addr = a; din = v; wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      addr = a; ren = 1'b1;
      @(negedge clk);
      ren = 1'b0;
   endtask

   task automatic init();
      Rst = 1'b0; loop = 1'b0; rx_drv = 1'b1;
      repeat (3) @(negedge clk);
      Rst = 1'b1;
      @(negedge clk);
      wr(2'd3, 8'd3);
      repeat (40) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx_drv = b;
      repeat (64) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] v, input logic par_en, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      if (par_en) send_bit(par);
      send_bit(stop);
      rx_drv = 1'b1;
   endtask

   task automatic wait_tx_low(input string nm);
      n = 1;
      while (tx0 !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tot_n++;
      if (n <= 5) pass_n++;
      else $display("FAIL %s: tx low after %0d clks, required <= 5", nm, n);
   endtask

   initial begin
      vt[0]  = '{2'd3, 1'b0, 1'b1, 8'h00, 8'h1A, 1'b0};
      vt[1]  = '{2'd2, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
      vt[2]  = '{2'd1, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0};
      vt[3]  = '{2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
      vt[4]  = '{2'd2, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1};
      vt[5]  = '{2'd2, 1'b0, 1'b1, 8'h00, 8'h07, 1'b1};
      vt[6]  = '{2'd1, 1'b1, 1'b0, 8'hFF, 8'h07, 1'b1};
      vt[7]  = '{2'd1, 1'b0, 1'b1, 8'h00, 8'h04, 1'b1};
      vt[8]  = '{2'd3, 1'b1, 1'b0, 8'h03, 8'h04, 1'b1};
      vt[9]  = '{2'd3, 1'b0, 1'b1, 8'h00, 8'h03, 1'b1};
      vt[10] = '{2'd2, 1'b1, 1'b0, 8'h01, 8'h03, 1'b0};
      vt[11] = '{2'd2, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_tx", tx0, 1'b1);
      chk("rst_tx_par", tx1, 1'b1);
      chk("rst_dout", dout0, 8'h00);
      chk("rst_irq", irq0, 1'b0);
      Rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         addr = vt[i].a; wen = vt[i].w; ren = vt[i].r; din = vt[i].d;
         @(negedge clk);
         wen = 1'b0; ren = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d_dout", i), dout0, vt[i].e_dout);
         chk($sformatf("vec%0d_irq", i), irq0, vt[i].e_irq);
      end

      // 0x55 at DIV=3: 64 clks per bit, alternating line
      init();
      wr(2'd0, 8'h55);
      wait_tx_low("tx55_latency");
      fr = {1'b1, 8'h55, 1'b0};
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("tx55_bit%0d_first", k), tx0, fr[k]);
         repeat (63) @(negedge clk);
         chk($sformatf("tx55_bit%0d_last", k), tx0, fr[k]);
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      rd(2'd1);
      chk("tx55_status_idle", dout0, 8'h04);

      // loopback, back-to-back frames
      init();
      loop = 1'b1;
      wr(2'd0, 8'hA3); sb.push_back(8'hA3);
      wr(2'd0, 8'h0F); sb.push_back(8'h0F);
      wait_tx_low("loop_latency");
      repeat (639) @(negedge clk);
      chk("loop_stop_bit", tx0, 1'b1);
      @(negedge clk);
      chk("loop_gapfree_start", tx0, 1'b0);
      repeat (700) @(negedge clk);
      rd(2'd0); chk("loop_rd0", dout0, sb.pop_front());
      rd(2'd0); chk("loop_rd1", dout0, sb.pop_front());
      rd(2'd0); chk("loop_rd_empty", dout0, 8'h00);

      // RX overrun: 17 frames into a 16-deep FIFO
      init();
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom);
         if (i < 16) sb.push_back(d);
         send_frame(d, 1'b0, 1'b0, 1'b1);
         repeat (16) @(negedge clk);
      end
      wr(2'd0, 8'hC3);
      rd(2'd1); chk("ovr_status", dout0, 8'h09);
      rd(2'd1); chk("ovr_status_cleared", dout0, 8'h01);
      for (int i = 0; i < 16; i++) begin
         rd(2'd0);
         chk($sformatf("ovr_data%0d", i), dout0, sb.pop_front());
      end
      rd(2'd0); chk("ovr_empty", dout0, 8'h00);

      // parity and framing error on the even-parity instance
      init();
      wr(2'd2, 8'h04);
      send_frame(8'h01, 1'b1, 1'b0, 1'b0);
      repeat (100) @(negedge clk);
      chk("perr_irq", irq1, 1'b1);
      repeat (50) @(negedge clk);
      chk("perr_irq_held", irq1, 1'b1);
      rd(2'd1); chk("perr_status", dout1, 8'h35);
      @(negedge clk);
      chk("perr_irq_cleared", irq1, 1'b0);

      // short low glitch on rx
      init();
      rx_drv = 1'b0;
      repeat (12) @(negedge clk);
      rx_drv = 1'b1;
      repeat (200) @(negedge clk);
      rd(2'd1); chk("glitch_status", dout0, 8'h04);
      rd(2'd0); chk("glitch_data", dout0, 8'h00);

      // reset in the middle of the second loopback frame
      init();
      loop = 1'b1;
      wr(2'd2, 8'h01);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
      wait_tx_low("rst_mid_latency");
      repeat (940) @(negedge clk);
      rd(2'd3); chk("pre_rst_div", dout0, 8'h03);
      chk("pre_rst_irq", irq0, 1'b1);
      chk("pre_rst_tx", tx0, 1'b0);
      Rst = 1'b0;
      #1;
      chk("mid_rst_tx", tx0, 1'b1);
      chk("mid_rst_irq", irq0, 1'b0);
      chk("mid_rst_dout", dout0, 8'h00);
      @(negedge clk);
      Rst = 1'b1;
      repeat (700) @(negedge clk);
      rd(2'd3); chk("post_rst_div", dout0, 8'h1A);
      rd(2'd2); chk("post_rst_ier", dout0, 8'h00);
      rd(2'd1); chk("post_rst_status", dout0, 8'h04);
      rd(2'd0); chk("post_rst_data", dout0, 8'h00);

      // simultaneous write and read: write wins, dout holds
      init();
      loop = 1'b1;
      wr(2'd2, 8'h05);
      rd(2'd2); chk("wr_rd_pre", dout0, 8'h05);
      addr = 2'd0; din = 8'h3C; wen = 1'b1; ren = 1'b1;
      sb.push_back(8'h3C);
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
      chk("wr_rd_hold", dout0, 8'h05);
      wait_tx_low("wr_rd_latency");
      repeat (700) @(negedge clk);
      rd(2'd0); chk("wr_rd_data", dout0, sb.pop_front());

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter DATA_BITS, 8, serial data bits per frame; legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of 2, at least 2.
REQ-003 Parameter DEF_DIV, 26, reset value of the divisor register; one 16x-baud tick every DIV+1 clocks.
REQ-004 Parameter PARITY_EN, 0, when 1 a single even-parity bit follows the data bits.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 Rst  in  1  asynchronous active-low reset (0 = reset).
REQ-007 rx  in  1  serial receive line, idle high, asynchronous to clk.
REQ-008 tx  out  1  serial transmit line, idle high.
REQ-009 uart_addr  in  2  register select: 0 DATA, 1 STATUS, 2 IER, 3 DIV.
REQ-010 tx_wen  in  1  register write strobe, one clk per access.
REQ-011 rx_ren  in  1  register read strobe, one clk per access.
REQ-012 uart_din  in  8  write data.
REQ-013 uart_dout  out  8  registered read data.
REQ-014 uart_IRQ  out  1  registered level interrupt.

Function
REQ-015 Writes: DATA pushes uart_din[DATA_BITS-1:0] into the TX FIFO; a push while the TX FIFO is full is dropped and sets sticky TXOVR.
REQ-016 Writes: IER stores bits[2:0]; DIV stores all 8 bits; a write to STATUS has no effect.
REQ-017 Reads: uart_dout is updated on the clk edge that samples rx_ren and holds until the next read.
REQ-018 Read of DATA returns the RX FIFO head zero-extended and pops it; on an empty FIFO it returns 0x00 with no pop.
REQ-019 Read of STATUS returns: bit0 RX non-empty; bit1 TX FIFO full; bit2 TX idle (FIFO empty and shifter idle); bit3 RXOVR; bit4 FERR; bit5 PERR; bit6 TXOVR; bit7 0.
REQ-020 Read of STATUS clears bits 3..6 on the same edge; an error event in that same cycle stays set.
REQ-021 Reads of IER and DIV return their stored values.
REQ-022 tx_wen and rx_ren asserted in the same cycle: the write executes; the read is ignored and uart_dout holds.
REQ-023 Baud generator: a counter reloads from DIV and emits a one-clk tick at zero; a DIV write takes effect at the next reload.
REQ-024 Frame: start bit 0, DATA_BITS bits LSB first, optional parity, one stop bit 1; each bit lasts 16 ticks.
REQ-025 TX FSM states IDLE, START, DATA, PARITY (only when PARITY_EN), STOP; the IDLE->START transition pops the FIFO on the first tick with the FIFO non-empty.
REQ-026 TX FSM: STOP returns to IDLE, or goes directly to START when the FIFO is non-empty (back-to-back frames).
REQ-027 rx passes through a two-flop synchronizer before any use.
REQ-028 RX FSM states IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-029 RX START: at tick 8 the line is sampled; if high (glitch) the FSM returns to IDLE and nothing is pushed.
REQ-030 RX sampling: each later bit is sampled at tick 16 after the previous sample (bit centre).
REQ-031 RX stop bit sampled 0 sets FERR; a parity mismatch sets PERR; the byte is still pushed.
REQ-032 RX frame-complete push on a full RX FIFO drops the byte and sets RXOVR.
REQ-033 RX FIFO internal push and bus pop in the same cycle: on a full FIFO both succeed; on an empty FIFO the push succeeds and the read returns 0x00.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
REQ-035 uart_IRQ is registered from (IER0 & RX non-empty) | (IER1 & TX idle) | (IER2 & (RXOVR|FERR|PERR|TXOVR)).

Reset
REQ-036 While Rst=0: both FIFOs are empty, both FSMs are IDLE, and IER and all sticky bits are 0.
REQ-037 While Rst=0: DIV=DEF_DIV, tx=1, uart_dout=0x00, uart_IRQ=0.
REQ-038 Reset asserted mid-frame aborts the frame immediately (tx=1); no partial byte is pushed after reset release.

Verification
REQ-039 DIV=3, write 0x55 to DATA: tx goes low within 5 clks; each bit lasts 64 clks; the line carries 0,1,0,1,0,1,0,1,0,1; STATUS bit2 returns to 1.
REQ-040 Loopback tx->rx, write 0xA3 then 0x0F back-to-back: the frames are gap-free; DATA reads return 0xA3 then 0x0F, then 0x00.
REQ-041 Inject FIFO_DEPTH+1 frames without reading: STATUS reads 0x09 (bit3 set); the next STATUS read returns 0x01; the first FIFO_DEPTH bytes are intact.
REQ-042 PARITY_EN=1, drive 0x01 with parity 0 and stop 0: STATUS bits 4 and 5 are set; with IER=0x4, uart_IRQ=1 until STATUS is read.
REQ-043 A 3-tick low glitch on rx pushes nothing; pulse Rst=0 mid TX frame: tx=1 and all registers return to reset values on the same edge.
REQ-044 Simultaneous tx_wen (DATA) and rx_ren: the byte is queued and uart_dout is unchanged.
